pacman_sound_seq: RTL

- Sequencer for a sound-effect ROM: 10-bit address, 9-bit data, one-cycle registered read. The eat-ghost effect ROM is the first client.
- On a trigger, walks the ROM from address 0 and holds each entry for a fixed number of clock cycles. Each entry is a tone half-period and drives a square-wave output.
- Stops at the end-marker entry (511). Sits between game-event logic and the audio pin/DAC.

---
 rtl/pacman_sound_pkg.sv | 7 +
 rtl/pacman_tone_gen.sv | 34 +++
 rtl/pacman_sound_seq.sv | 87 ++++++++
 3 files changed

// File: rtl/pacman_sound_pkg.sv
// pacman_sound_pkg: state type and defaults shared by the effect ROM sequencers
package pacman_sound_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PLAY, FIN} state_e;
  localparam int DEF_END_CODE = 511;
  localparam int DEF_STEP_CYCLES = 50000;
  localparam int DEF_PERIOD_SCALE = 64;
endpackage

// File: rtl/pacman_tone_gen.sv
// pacman_tone_gen: square wave with a half-period of period_i*SCALE clocks
module pacman_tone_gen #(
  parameter int DATA_W = 9,
  parameter int SCALE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              mute_i,
  input  logic [DATA_W-1:0] period_i,
  output logic              tone_o
);
  localparam int SH = $clog2(SCALE);
  localparam int CW = DATA_W + SH;
  logic [CW-1:0] cnt_q, lim;
  logic tone_q;
  assign lim = (CW'(period_i) << SH) - CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      tone_q <= 1'b0;
    end else if (mute_i) begin
      cnt_q <= '0;
      tone_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (period_i == '0 || cnt_q == lim) ? '0 : cnt_q + CW'(1);
      tone_q <= (period_i == '0) ? 1'b0 : tone_q ^ (cnt_q == lim);
    end
  // a zero period silences the pin for the whole entry, including its first cycle
  assign tone_o = tone_q & |period_i;
endmodule

// File: rtl/pacman_sound_seq.sv
// pacman_sound_seq: walks a sound-effect ROM, holding each half-period entry for STEP_CYCLES clocks
module pacman_sound_seq import pacman_sound_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9,
  parameter int END_CODE = DEF_END_CODE,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int PERIOD_SCALE = DEF_PERIOD_SCALE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] tone_period_o,
  output logic              tone_out_o
);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  state_e state_q;
  logic [SW-1:0] step_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] period_q;
  logic busy_q, done_q, kill, is_end;
  assign kill = stop_i && state_q != IDLE;
  assign is_end = rom_data_i == DATA_W'(END_CODE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      addr_q <= '0;
      period_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (kill) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      state_q <= ADDR;
      addr_q <= '0;
      step_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: state_q <= WAIT;
        WAIT: begin
          state_q <= is_end ? FIN : PLAY;
          done_q <= is_end;
          step_q <= '0;
          if (!is_end) period_q <= rom_data_i;
        end
        PLAY:
          if (step_q == SW'(STEP_CYCLES - 1)) begin
            step_q <= '0;
            state_q <= &addr_q ? FIN : ADDR;
            done_q <= &addr_q;
            if (!(&addr_q)) addr_q <= addr_q + ADDR_W'(1);
          end else begin
            step_q <= step_q + SW'(1);
          end
        FIN: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  // restart keeps the tone level; only going idle silences it
  pacman_tone_gen #(.DATA_W(DATA_W), .SCALE(PERIOD_SCALE)) u_tone (
    .clk(clk),
    .rst(rst),
    .en_i(state_q == PLAY),
    .clear_i(start_i || state_q == WAIT),
    .mute_i(kill || (state_q == FIN && !start_i)),
    .period_i(period_q),
    .tone_o(tone_out_o)
  );
  assign rom_addr_o = addr_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign tone_period_o = period_q;
endmodule
